// File: rtl/paralelo_serial_lane_pkg.sv
// Shared constants for the per-lane parallel-to-serial converter.
`timescale 1ns/1ps
package paralelo_serial_lane_pkg;
  localparam int          LANE_WIDTH = 8;
  localparam logic [7:0]  K28_5      = 8'hBC;
  localparam int          CNT_W      = $clog2(LANE_WIDTH);
endpackage

// File: rtl/paralelo_serial_lane.sv
// Per-lane parallel-to-serial converter: one-deep holding buffer in front of
// an MSB-first shift register; idle/comma frames fill any gap in the data.
`timescale 1ns/1ps
module paralelo_serial_lane
  import paralelo_serial_lane_pkg::*;
#(
  parameter int               WIDTH     = LANE_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_BYTE = K28_5
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             byte_start,
  output logic             sending_data
);

  // Counter width follows WIDTH; the package value covers the default lane.
  localparam int             CW   = (WIDTH == LANE_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] sreg_q,      sreg_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic             data_flag_q, data_flag_d;
  logic             load;
  logic             accept;

  // Handshake and frame-boundary decode.
  always_comb begin
    load      = (cnt_q == LAST);
    ready_out = reset & (~hold_full_q | load);
    accept    = valid_in & ready_out;
  end

  // Next-state: counter, shift/load of the frame, and buffer occupancy.
  always_comb begin
    cnt_d       = load ? '0 : cnt_q + 1'b1;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    data_flag_d = data_flag_q;
    if (load) begin
      if (hold_full_q) begin
        // Buffered byte drains; a byte accepted on the same edge refills it.
        sreg_d      = hold_q;
        data_flag_d = 1'b1;
        hold_full_d = accept;
        if (accept) hold_d = lane_in;
      end else if (valid_in) begin
        // Empty buffer at a frame boundary: bypass straight into the shifter.
        sreg_d      = lane_in;
        data_flag_d = 1'b1;
      end else begin
        sreg_d      = IDLE_BYTE;
        data_flag_d = 1'b0;
      end
    end else begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      if (accept) begin
        hold_d      = lane_in;
        hold_full_d = 1'b1;
      end
    end
  end

  // Control and shift state; reset discards the frame in flight and the buffer.
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      cnt_q       <= LAST;
      sreg_q      <= '0;
      hold_full_q <= 1'b0;
      data_flag_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      hold_full_q <= hold_full_d;
      data_flag_q <= data_flag_d;
    end
  end

  // Buffer payload; only meaningful while hold_full_q is set.
  always_ff @(posedge clk_8f) begin
    hold_q <= hold_d;
  end

  // Serial outputs; byte_start is masked while reset is asserted.
  always_comb begin
    serial_out   = sreg_q[WIDTH-1];
    byte_start   = reset & (cnt_q == '0);
    sending_data = data_flag_q;
  end

endmodule

// File: tb/tb_paralelo_serial_lane.sv
// Testbench for paralelo_serial_lane: directed scenarios followed by random
// traffic, checked against a queue-based lane model and a frame scoreboard.
`timescale 1ns/1ps
module tb_paralelo_serial_lane;

  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_8f;
  logic       reset;
  logic [7:0] lane_in;
  logic       valid_in;
  logic       ready_out;
  logic       serial_out;
  logic       byte_start;
  logic       sending_data;

  paralelo_serial_lane dut (
    .clk_8f       (clk_8f),
    .reset        (reset),
    .lane_in      (lane_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .serial_out   (serial_out),
    .byte_start   (byte_start),
    .sending_data (sending_data)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         tests = 0;
  int         fails = 0;
  // Lane model: edges since reset release, accepted-but-unsent bytes, frame on air.
  int         e;
  logic [7:0] pend[$];
  logic [7:0] acc_log[$];
  logic [7:0] cur;
  bit         cur_data;
  // Observed frames as {sending_data, byte}, plus the deserializer.
  logic [8:0] frames[$];
  logic [7:0] rx;
  bit         frame_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; valid_in = 1'b0; lane_in = 8'h00;
    #1;
    chk("rst_ready", ready_out, 1'b0);
    repeat (n) begin
      @(posedge clk_8f);
      @(negedge clk_8f);
      chk("rst_serial", serial_out, 1'b0);
      chk("rst_bstart", byte_start, 1'b0);
      chk("rst_sending", sending_data, 1'b0);
      chk("rst_ready2", ready_out, 1'b0);
    end
    reset = 1'b1;
    e = 0; pend.delete(); acc_log.delete(); rx = 8'h00; frame_done = 1'b0;
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic step(input bit v, input logic [7:0] d, output bit acc);
    bit load; bit exp_rdy; int ph;
    valid_in = v; lane_in = d;
    load    = (e % 8 == 0);
    exp_rdy = (pend.size() == 0) || load;
    #1;
    chk("ready_out", ready_out, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk_8f);
    if (acc) begin pend.push_back(d); acc_log.push_back(d); end
    if (load) begin
      if (pend.size() > 0) begin cur = pend.pop_front(); cur_data = 1'b1; end
      else begin cur = IDLE; cur_data = 1'b0; end
    end
    ph = e % 8;
    e++;
    @(negedge clk_8f);
    chk("serial_out", serial_out, cur[7-ph]);
    chk("byte_start", byte_start, (ph == 0));
    chk("sending_data", sending_data, cur_data);
    rx = {rx[6:0], serial_out};
    frame_done = (ph == 7);
    if (frame_done) begin
      frames.push_back({sending_data, rx});
      if (sending_data) begin
        chk("sb_avail", (acc_log.size() > 0), 1'b1);
        if (acc_log.size() > 0) chk("sb_byte", rx, acc_log.pop_front());
      end else begin
        chk("sb_idle", rx, IDLE);
      end
    end
  endtask

  task automatic run_to_frame_end();
    bit a; int n;
    n = 0;
    do begin step(1'b0, 8'h00, a); n++; end while (!frame_done && n < 16);
    chk("frame_end_bound", frame_done, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, output int waited);
    bit a;
    waited = 0;
    do begin step(1'b1, d, a); if (!a) waited++; end while (!a && waited < 32);
    chk("send_bound", a, 1'b1);
  endtask

  initial begin
    bit         a;
    bit         have;
    logic [7:0] rd;
    int         w0, w1, w2;
    reset = 1'b0; valid_in = 1'b0; lane_in = 8'h00;
    cur = 8'h00; cur_data = 1'b0;
    do_reset(2);

    // Idle after reset: three comma frames.
    frames.delete();
    repeat (24) step(1'b0, 8'h00, a);
    chk("idle_nframes", frames.size(), 3);
    for (int i = 0; i < frames.size(); i++) chk("idle_frame", frames[i], {1'b0, IDLE});

    // Single byte accepted mid-frame goes out as the next frame.
    frames.delete();
    repeat (3) step(1'b0, 8'h00, a);
    step(1'b1, 8'hA5, a);
    repeat (3) run_to_frame_end();
    chk("a5_nframes", frames.size(), 3);
    if (frames.size() == 3) begin
      chk("a5_prev", frames[0], {1'b0, IDLE});
      chk("a5_frame", frames[1], {1'b1, 8'hA5});
      chk("a5_after", frames[2], {1'b0, IDLE});
    end

    // Back-to-back bytes with backpressure.
    frames.delete();
    send(8'h01, w0);
    send(8'h02, w1);
    send(8'h03, w2);
    chk("bp_wait0", w0, 0);
    chk("bp_wait1", w1, 0);
    chk("bp_wait2", w2, 6);
    repeat (3) run_to_frame_end();
    chk("bp_nframes", frames.size(), 4);
    if (frames.size() == 4) begin
      chk("bp_f1", frames[0], {1'b1, 8'h01});
      chk("bp_f2", frames[1], {1'b1, 8'h02});
      chk("bp_f3", frames[2], {1'b1, 8'h03});
      chk("bp_f4", frames[3], {1'b0, IDLE});
    end

    // Bypass at a frame boundary with the buffer empty.
    frames.delete();
    step(1'b1, 8'h3C, a);
    chk("bypass_msb", serial_out, 1'b0);
    chk("bypass_flag", sending_data, 1'b1);
    valid_in = 1'b0;
    #1;
    chk("bypass_hold_empty", ready_out, 1'b1);
    repeat (2) run_to_frame_end();
    chk("bypass_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("bypass_frame", frames[0], {1'b1, 8'h3C});
      chk("bypass_after", frames[1], {1'b0, IDLE});
    end

    // Reset mid-frame with the buffer full discards the buffered byte.
    repeat (2) step(1'b0, 8'h00, a);
    step(1'b1, 8'h55, a);
    valid_in = 1'b0;
    #1;
    chk("pre_rst_full", ready_out, 1'b0);
    do_reset(1);
    frames.delete();
    repeat (2) run_to_frame_end();
    chk("rst_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("rst_frame0", frames[0], {1'b0, IDLE});
      chk("rst_frame1", frames[1], {1'b0, IDLE});
    end

    // Random traffic; a presented byte is held until it is accepted.
    have = 1'b0; rd = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      bit v;
      v = ($urandom_range(0, 99) < 40);
      if (v && !have) begin rd = 8'($urandom); have = 1'b1; end
      step(v, rd, a);
      if (a) have = 1'b0;
    end
    repeat (3) run_to_frame_end();
    chk("sb_drained", acc_log.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
